// File: rtl/lc3_mem_ctrl_if.sv
// Datapath-side memory bus of the LC-3 memory controller: MAR/MDR, MIO.EN, R.W and the R ready pulse.
interface lc3_mem_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr_in;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] mdr_out;

    modport master (output req, we, mar, mdr_in, input rdy, mdr_out);
    modport slave  (input req, we, mar, mdr_in, output rdy, mdr_out);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: routes datapath accesses to RAM or to the KBSR/KBDR/DSR/DDR/MCR
// device registers, and owns the keyboard/display handshakes and the run bit.
module lc3_mem_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'hFE00
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3_mem_ctrl_if.slave         cpu,
    output logic                  ram_cs,
    output logic                  ram_r_w,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic                  ram_ready,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_data,
    output logic                  kb_ack,
    output logic                  disp_valid,
    output logic [7:0]            disp_data,
    input  logic                  disp_ready,
    output logic                  kb_irq,
    output logic                  disp_irq,
    output logic                  run
);
    localparam logic [ADDR_WIDTH-1:0] KBSR_ADDR = ADDR_WIDTH'(16'hFE00);
    localparam logic [ADDR_WIDTH-1:0] KBDR_ADDR = ADDR_WIDTH'(16'hFE02);
    localparam logic [ADDR_WIDTH-1:0] DSR_ADDR  = ADDR_WIDTH'(16'hFE04);
    localparam logic [ADDR_WIDTH-1:0] DDR_ADDR  = ADDR_WIDTH'(16'hFE06);
    localparam logic [ADDR_WIDTH-1:0] MCR_ADDR  = ADDR_WIDTH'(16'hFFFE);

    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WAIT, IO_ACC, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] io_rdata;
    logic                  io_rd, io_wr, kbdr_read, ddr_write;
    logic                  kb_rdy, kb_ie, dsr_rdy, dsr_ie, run_q;
    logic [7:0]            kbdr;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cpu.rdy    = 1'b0;
        ram_cs     = 1'b0;
        ram_r_w    = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        case (state)
            IDLE:     if (cpu.req) state_next = (cpu.mar < IO_BASE) ? RAM_ACC : IO_ACC;
            RAM_ACC: begin
                ram_cs     = 1'b1;
                ram_r_w    = we_q;
                state_next = RAM_WAIT;
            end
            RAM_WAIT: if (ram_ready) state_next = DONE;
            IO_ACC: begin
                io_rd      = ~we_q;
                io_wr      = we_q;
                state_next = DONE;
            end
            DONE: begin
                cpu.rdy    = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    assign kbdr_read = io_rd && (addr_q == KBDR_ADDR);
    assign ddr_write = io_wr && (addr_q == DDR_ADDR);

    always_comb begin
        io_rdata = '0;
        case (addr_q)
            KBSR_ADDR: begin
                io_rdata[DATA_WIDTH-1] = kb_rdy;
                io_rdata[DATA_WIDTH-2] = kb_ie;
            end
            KBDR_ADDR: io_rdata[7:0] = kbdr;
            DSR_ADDR: begin
                io_rdata[DATA_WIDTH-1] = dsr_rdy;
                io_rdata[DATA_WIDTH-2] = dsr_ie;
            end
            MCR_ADDR:  io_rdata[DATA_WIDTH-1] = run_q;
            default:   io_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else if (state == IDLE && cpu.req) begin
            addr_q <= cpu.mar;
            data_q <= cpu.mdr_in;
            we_q   <= cpu.we;
        end
    end

    // mdr_out only changes when a read completes; writes leave it untouched.
    always_ff @(posedge clk) begin
        if (reset)                                   mdr_q <= '0;
        else if (state == RAM_WAIT && ram_ready && !we_q) mdr_q <= ram_data_out;
        else if (io_rd)                              mdr_q <= io_rdata;
    end

    // A KBDR read blocks acceptance for that cycle so the read sees the old character.
    assign kb_ack = kb_valid && !kb_rdy && !kbdr_read && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            kb_rdy <= 1'b0;
            kb_ie  <= 1'b0;
            kbdr   <= '0;
        end else begin
            if (io_wr && addr_q == KBSR_ADDR) kb_ie <= data_q[DATA_WIDTH-2];
            if (kb_ack) begin
                kbdr   <= kb_data;
                kb_rdy <= 1'b1;
            end else if (kbdr_read) begin
                kb_rdy <= 1'b0;
            end
        end
    end

    // A DDR write wins over a same-cycle display consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsr_rdy    <= 1'b1;
            dsr_ie     <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            if (io_wr && addr_q == DSR_ADDR) dsr_ie <= data_q[DATA_WIDTH-2];
            if (ddr_write) begin
                disp_data  <= data_q[7:0];
                disp_valid <= 1'b1;
                dsr_rdy    <= 1'b0;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
                dsr_rdy    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                             run_q <= 1'b1;
        else if (io_wr && addr_q == MCR_ADDR)  run_q <= data_q[DATA_WIDTH-1];
    end

    assign cpu.mdr_out = mdr_q;
    assign ram_addr    = addr_q;
    assign ram_data_in = data_q;
    assign kb_irq      = kb_rdy & kb_ie;
    assign disp_irq    = dsr_rdy & dsr_ie;
    assign run         = run_q;
endmodule
